// File: rtl/btn_move_decoder_if.sv
// Move handshake between the button decoder and the game controller.
// The decoder presents move_dir with move_valid; the controller accepts a move with move_ready.
interface btn_move_decoder_if;
    logic       move_valid;
    logic       move_ready;
    logic [1:0] move_dir;

    modport master (output move_valid, output move_dir, input  move_ready);
    modport slave  (input  move_valid, input  move_dir, output move_ready);
endinterface

// File: rtl/btn_move_decoder.sv
// Four-button debouncer and move issuer: one move per press, held until the
// controller accepts it, then no new move until all buttons are released.

module btn_debounce #(
    parameter logic [15:0] DB_CYCLES   = 16'd1000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            cnt_q;
    logic                   level_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = level & ~level_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            level_d <= level;
            // Level flips on the DB_CYCLES-th consecutive differing sample.
            if (synced == level) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_CYCLES - 16'd1) begin
                cnt_q <= '0;
                level <= ~level;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end
endmodule

module btn_move_decoder #(
    parameter logic [15:0] DB_CYCLES   = 16'd1000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       btnL,
    input  logic                       btnR,
    input  logic                       btnU,
    input  logic                       btnD,
    btn_move_decoder_if.master         mv,
    output logic [3:0]                 btn_db,
    output logic [7:0]                 drop_cnt
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, PEND, WAIT_REL} state_t;

    logic [NUM_LANES-1:0] raw, lvl, press;
    state_t               state_q, state_d;
    logic [1:0]           dir_q, dir_d;
    logic [2:0]           n_press, n_drop;
    logic [8:0]           drop_sum;

    // Lane order matches btn_db: {U,D,L,R}.
    assign raw    = {btnU, btnD, btnL, btnR};
    assign btn_db = lvl;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        btn_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_db (
            .clk   (clk),
            .clr   (clr),
            .raw   (raw[g]),
            .level (lvl[g]),
            .rise  (press[g])
        );
    end

    always_comb begin
        n_press = '0;
        for (int i = 0; i < NUM_LANES; i++) n_press = n_press + {2'b00, press[i]};
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        n_drop  = n_press;
        case (state_q)
            IDLE: begin
                if (|press) begin
                    state_d = PEND;
                    n_drop  = n_press - 3'd1;
                    if      (press[3]) dir_d = 2'b10;
                    else if (press[2]) dir_d = 2'b11;
                    else if (press[1]) dir_d = 2'b00;
                    else               dir_d = 2'b01;
                end
            end
            PEND:     if (mv.move_ready) state_d = WAIT_REL;
            WAIT_REL: if (lvl == '0)     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign drop_sum = {1'b0, drop_cnt} + {6'b0, n_drop};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            dir_q    <= 2'b00;
            drop_cnt <= 8'h00;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Decoded straight from state so valid never depends on ready.
    assign mv.move_valid = (state_q == PEND);
    assign mv.move_dir   = dir_q;
endmodule

// File: doc/btn_move_decoder.md
BTN_MOVE_DECODER -- requirements
Module: btn_move_decoder

Interface
REQ-001 Parameter DB_CYCLES, default 16'd1000: consecutive stable synchronized samples required before a debounced level changes; legal range 2..65535.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizer; legal values 2 or 3.
REQ-003 clk  input  1  block clock; same clock as the game controller (segclk domain).
REQ-004 clr  input  1  reset, asynchronous assert, active-low.
REQ-005 btnL  input  1  raw left pushbutton, asynchronous, active-high, bouncy.
REQ-006 btnR  input  1  raw right pushbutton, same properties as btnL.
REQ-007 btnU  input  1  raw up pushbutton, same properties as btnL.
REQ-008 btnD  input  1  raw down pushbutton, same properties as btnL.
REQ-009 move_ready  input  1  game controller can accept a move this cycle.
REQ-010 move_valid  output  1  a move command is presented on move_dir.
REQ-011 move_dir  output  2  move direction: 00=L, 01=R, 10=U, 11=D.
REQ-012 btn_db  output  4  debounced levels {U,D,L,R}, MSB first.
REQ-013 drop_cnt  output  8  count of press events discarded, saturating.

Function
REQ-014 Each button SHALL pass through a SYNC_STAGES-deep synchronizer before any other logic uses it.
REQ-015 Each button SHALL have its own 16-bit debounce counter.
- Synchronized level equal to debounced level: the counter clears.
- Otherwise the counter increments.
- On reaching DB_CYCLES-1, the debounced level toggles and the counter clears.
- Result: the debounced level changes exactly DB_CYCLES cycles after the synchronized input settles.
REQ-016 A press event SHALL be a 0->1 transition of a debounced level, one cycle wide.
REQ-017 The FSM SHALL have three states: IDLE, PEND and WAIT_REL.
REQ-018 In IDLE with one or more press events, the FSM SHALL capture one direction into move_dir and go to PEND the next cycle.
- Priority for simultaneous events: U > D > L > R.
REQ-019 In PEND, move_valid SHALL be 1 and move_dir SHALL stay constant until a handshake.
- Handshake = move_valid & move_ready in the same cycle.
- After the handshake, the FSM goes to WAIT_REL the next cycle.
REQ-020 move_ready SHALL NOT be required to be high for the FSM to enter PEND.
- move_valid SHALL NOT depend combinationally on move_ready.
REQ-021 In WAIT_REL, move_valid SHALL be 0.
- The FSM returns to IDLE on the first cycle in which btn_db == 4'b0000.
REQ-022 Every press event not captured SHALL increment drop_cnt by 1.
- Covers press events arriving in PEND or WAIT_REL.
- Covers the lower-priority events of a simultaneous set in IDLE.
- Several events in one cycle add their total count.
- drop_cnt saturates at 8'hFF.
REQ-023 Latency: a handshake in cycle N SHALL make move_valid 0 in cycle N+1.
- Only one move is issued per handshake.
REQ-024 Releases (1->0 debounced transitions) SHALL NOT generate events or drop counts.

Reset
REQ-025 While clr=0, the block SHALL be held in reset, asynchronously.
- FSM = IDLE.
- move_valid = 0, move_dir = 2'b00.
- btn_db = 4'b0000, drop_cnt = 8'h00.
- All synchronizer and debounce registers = 0.
REQ-026 Reset asserted in PEND SHALL abandon the pending move; no move is issued after release.
REQ-027 After clr deasserts, a button already held SHALL produce one press event after sync latency plus DB_CYCLES cycles.

Verification
REQ-028 DB_CYCLES=8. btnU pulses 1-0-1-0 for 3 cycles each, then holds high 20 cycles -> btn_db[3] rises once, 8 cycles after the stable level is synchronized; one move_valid with move_dir=10.
REQ-029 btnL and btnR debounced high in the same cycle, move_ready=1 -> move_dir=00 presented for one handshake cycle; drop_cnt=1; FSM in WAIT_REL until both released.
REQ-030 move_ready held 0 for 50 cycles after a btnD press -> move_valid=1 and move_dir=11 stable throughout; move_ready=1 -> one-cycle handshake, move_valid=0 the next cycle.
REQ-031 300 press events injected in PEND -> drop_cnt=8'hFF, no wrap; no extra moves issued.
REQ-032 clr pulled low while in PEND with move_dir=01 -> all outputs at reset values immediately; no move_valid after release while buttons stay low.
REQ-033 btnR held through WAIT_REL, then btnL pressed -> no new move until btn_db==0; the later btnL press issues move_dir=00.
